bk_adder_pipe: RTL and testbench
================================

BK_ADDER_PIPE -- requirements
Module: bk_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be a power of two, 4..64.
REQ-002 Parameter STAGES, default 2, pipeline depth in cycles; SHALL be 1..log2(WIDTH)+1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, used only when sub=0.
REQ-010 sub  input  1  mode: 0 = a+b+cin, 1 = a-b (a + ~b + 1).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  carry out of bit WIDTH-1; for sub=1, 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  sum == 0.

Function
REQ-017 Carries SHALL come from a Brent-Kung prefix tree: bitwise g=a&b', p=a^b' (b'=sub?~b:b); log2(WIDTH) up-sweep levels; log2(WIDTH)-1 down-sweep levels.
REQ-018 Effective carry-in SHALL be sub ? 1 : cin; carry[i] = G[i-1:0] | (P[i-1:0] & carry-in); sum = p ^ carry[WIDTH-1:0].
REQ-019 ovf SHALL equal carry[WIDTH] ^ carry[WIDTH-1]; zero SHALL be computed from the final sum in the last stage.
REQ-020 A beat SHALL transfer on the input when in_valid&in_ready, and on the output when out_valid&out_ready.
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no backpressure; the output register is always present, internal boundaries are placed after up-sweep levels, positions free.
REQ-022 Each stage holds a valid bit; stage k SHALL load when it is empty or stage k+1 loads this cycle (bubble collapsing); in_ready = stage-0 loads this cycle.
REQ-023 Throughput SHALL be one beat per cycle while out_ready=1; with out_ready=0 the pipeline SHALL fill to STAGES beats, then in_ready=0.
REQ-024 While out_valid=1 and out_ready=0, sum/cout/ovf/zero SHALL hold stable.
REQ-025 Simultaneous output transfer and input transfer on a full pipeline SHALL advance all stages with no loss or duplication.
REQ-026 sub and cin SHALL travel with their beat; mode may change every beat.
REQ-027 Carry out of bit WIDTH-1 SHALL not wrap; sum is modulo 2^WIDTH.
REQ-028 in_ready SHALL not depend on in_valid; out_valid SHALL not depend on out_ready.

Reset
REQ-029 rst=1 SHALL clear every valid bit immediately; out_valid=0, sum=0, cout=0, ovf=0, zero=0.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; none SHALL appear after release.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-032 Shared package bk_pkg SHALL hold the log2 helper function and the default WIDTH/STAGES constants.
REQ-033 One sub-module, bk_prefix_cell: (Gh,Ph,Gl,Pl) -> (Gh|Ph&Gl, Ph&Pl), SHALL be instantiated for every prefix node.
REQ-034 Datapath registers SHALL need no reset; only valid bits and output flags are reset.

Verification (WIDTH=16, STAGES=2 unless stated)
REQ-035 a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> after 2 cycles sum=0x0000, cout=1, zero=1, ovf=0.
REQ-036 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0; a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-037 Send 4 beats with out_ready=0 -> in_ready falls after 2 accepted; raise out_ready -> 4 results in order, no gaps, outputs stable while stalled.
REQ-038 Assert rst with 2 beats in flight -> out_valid=0 same cycle; no stale result after release.
REQ-039 10^5 random beats, random sub/cin and out_ready, WIDTH in {4,16,64}, STAGES in {1,max} -> all results match a+b'+cin' reference.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared constants and elaboration helpers for the pipelined Brent-Kung adder.
package bk_pkg;

  localparam int BK_DEFAULT_WIDTH  = 32;
  localparam int BK_DEFAULT_STAGES = 2;

  // Exact for the power-of-two operand widths the adder accepts.
  function automatic int bkLog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int bkMaxStages(input int width);
    return bkLog2(width) + 1;
  endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// One Brent-Kung prefix node: merges a high (g,p) span with the adjacent low span.
module bk_prefix_cell (
  input  logic i_gHi,
  input  logic i_pHi,
  input  logic i_gLo,
  input  logic i_pLo,
  output logic o_g,
  output logic o_p
);

  assign o_g = i_gHi | (i_pHi & i_gLo);
  assign o_p = i_pHi & i_pLo;

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready handshaking on both sides.
// Internal stage registers sit after the first STAGES-1 up-sweep levels; the output register is always last.
module bk_adder_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH  = BK_DEFAULT_WIDTH,
  parameter int STAGES = BK_DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LOGW = bkLog2(WIDTH);
  localparam int NLVL = 2 * LOGW - 1;

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_srcValid;
  logic [STAGES-1:0] w_capture;

  // A stage loads when empty or when its successor loads; the output stage's successor is the consumer.
  always_comb begin
    logic nextLoad;
    logic loadK;
    w_load     = '0;
    w_srcValid = '0;
    nextLoad   = out_ready;
    loadK      = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      loadK     = !r_valid[k] || nextLoad;
      w_load[k] = loadK;
      nextLoad  = loadK;
    end
    w_srcValid[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_srcValid[k] = r_valid[k-1];
    end
  end

  assign w_capture = w_load & w_srcValid;
  assign in_ready  = w_load[0];
  assign out_valid = r_valid[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      r_valid <= (r_valid & ~w_load) | (w_srcValid & w_load);
    end
  end

  logic [WIDTH-1:0] w_bEff;
  logic [WIDTH-1:0] w_lvlG   [1:NLVL];
  logic [WIDTH-1:0] w_lvlP   [1:NLVL];
  logic [WIDTH-1:0] w_outG   [0:NLVL];
  logic [WIDTH-1:0] w_outP   [0:NLVL];
  logic [WIDTH-1:0] w_outP0  [0:NLVL];
  logic             w_outCin [0:NLVL];

  assign w_bEff      = sub ? ~b : b;
  assign w_outG[0]   = a & w_bEff;
  assign w_outP[0]   = a ^ w_bEff;
  assign w_outP0[0]  = a ^ w_bEff;
  assign w_outCin[0] = sub | cin;

  // Levels 1..LOGW are the up-sweep, the rest the down-sweep; the bitwise p and carry-in ride alongside.
  for (genvar lv = 1; lv <= NLVL; lv++) begin : g_lvl
    localparam bit IS_UP = (lv <= LOGW);
    localparam int SPAN  = IS_UP ? (1 << (lv - 1)) : (1 << (2 * LOGW - lv - 1));

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam bit IS_NODE = IS_UP ? (((i + 1) % (2 * SPAN)) == 0)
                                     : ((((i + 1) % (2 * SPAN)) == SPAN) && (i >= 2 * SPAN));
      if (IS_NODE) begin : g_cell
        bk_prefix_cell u_cell (
          .i_gHi (w_outG[lv-1][i]),
          .i_pHi (w_outP[lv-1][i]),
          .i_gLo (w_outG[lv-1][i-SPAN]),
          .i_pLo (w_outP[lv-1][i-SPAN]),
          .o_g   (w_lvlG[lv][i]),
          .o_p   (w_lvlP[lv][i])
        );
      end else begin : g_pass
        assign w_lvlG[lv][i] = w_outG[lv-1][i];
        assign w_lvlP[lv][i] = w_outP[lv-1][i];
      end
    end

    if (lv <= STAGES - 1) begin : g_reg
      logic [WIDTH-1:0] r_g;
      logic [WIDTH-1:0] r_p;
      logic [WIDTH-1:0] r_p0;
      logic             r_cin;

      always_ff @(posedge clk) begin
        if (w_capture[lv-1]) begin
          r_g   <= w_lvlG[lv];
          r_p   <= w_lvlP[lv];
          r_p0  <= w_outP0[lv-1];
          r_cin <= w_outCin[lv-1];
        end
      end

      assign w_outG[lv]   = r_g;
      assign w_outP[lv]   = r_p;
      assign w_outP0[lv]  = r_p0;
      assign w_outCin[lv] = r_cin;
    end else begin : g_comb
      assign w_outG[lv]   = w_lvlG[lv];
      assign w_outP[lv]   = w_lvlP[lv];
      assign w_outP0[lv]  = w_outP0[lv-1];
      assign w_outCin[lv] = w_outCin[lv-1];
    end
  end

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  assign w_carry = {w_outG[NLVL] | (w_outP[NLVL] & {WIDTH{w_outCin[NLVL]}}), w_outCin[NLVL]};
  assign w_sum   = w_outP0[NLVL] ^ w_carry[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_capture[STAGES-1]) begin
      r_sum  <= w_sum;
      r_cout <= w_carry[WIDTH];
      r_ovf  <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
      r_zero <= (w_sum == '0);
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Self-checking bench for bk_adder_pipe: directed corner cases, backpressure, mid-flight reset,
// then randomized traffic scored against an arithmetic reference model.
module tb_bk_adder_pipe;

  localparam int W = 16;
  localparam int S = 2;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } expEntry_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         inValid;
  logic         inReady;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         cinIn;
  logic         subIn;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] sumOut;
  logic         coutOut;
  logic         ovfOut;
  logic         zeroOut;

  expEntry_t expQ[$];
  int checkCount = 0;
  int errorCount = 0;
  int pushCount  = 0;
  int popCount   = 0;

  logic         obsValid;
  logic         obsAccept;
  logic         obsInReady;
  logic [W-1:0] obsSum;
  logic         obsCout;
  logic         obsOvf;
  logic         obsZero;

  logic [W-1:0] edgeVals [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

  bk_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (opA),
    .b         (opB),
    .cin       (cinIn),
    .sub       (subIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .sum       (sumOut),
    .cout      (coutOut),
    .ovf       (ovfOut),
    .zero      (zeroOut)
  );

  always #5 clk = ~clk;

  // Reference: plain (W+1)-bit arithmetic; overflow from operand/result sign rule.
  function automatic expEntry_t refModel(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    logic [W-1:0] yEff;
    logic [W:0]   full;
    logic         cEff;
    expEntry_t    e;
    yEff   = s ? ~y : y;
    cEff   = s ? 1'b1 : c;
    full   = {1'b0, x} + {1'b0, yEff} + {{W{1'b0}}, cEff};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (x[W-1] == yEff[W-1]) && (e.sum[W-1] != x[W-1]);
    e.zero = (e.sum == '0);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic c, input logic s);
    inValid = v;
    opA     = x;
    opB     = y;
    cinIn   = c;
    subIn   = s;
  endtask

  // One clock: observe and score at the falling edge, then return just after the rising edge.
  task automatic stepCycle();
    expEntry_t front;
    @(negedge clk);
    obsValid   = outValid;
    obsInReady = inReady;
    obsAccept  = inValid && inReady;
    obsSum     = sumOut;
    obsCout    = coutOut;
    obsOvf     = ovfOut;
    obsZero    = zeroOut;
    if (!rst) begin
      if (outValid) begin
        if (expQ.size() == 0) begin
          checkOutput("spuriousOut", outValid, 1'b0);
        end else begin
          front = expQ[0];
          checkOutput("sum", sumOut, front.sum);
          checkOutput("cout", coutOut, front.cout);
          checkOutput("ovf", ovfOut, front.ovf);
          checkOutput("zero", zeroOut, front.zero);
          if (outReady) begin
            front = expQ.pop_front();
            popCount++;
          end
        end
      end
      if (obsAccept) begin
        expQ.push_back(refModel(opA, opB, cinIn, subIn));
        pushCount++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runSingle(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic c, input logic s, input logic [W-1:0] wantSum,
                           input logic wantCout, input logic wantOvf, input logic wantZero);
    int waitCycles;
    outReady = 1'b1;
    applyStimulus(1'b1, x, y, c, s);
    stepCycle();
    checkOutput({tag, "_accept"}, obsAccept, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    waitCycles = 0;
    do begin
      stepCycle();
      waitCycles++;
    end while (!obsValid && waitCycles < 20);
    checkOutput({tag, "_latency"}, waitCycles, S);
    checkOutput({tag, "_sum"}, obsSum, wantSum);
    checkOutput({tag, "_cout"}, obsCout, wantCout);
    checkOutput({tag, "_ovf"}, obsOvf, wantOvf);
    checkOutput({tag, "_zero"}, obsZero, wantZero);
  endtask

  task automatic backpressureTest();
    logic [W-1:0] bpA [4];
    logic [W-1:0] bpB [4];
    logic [31:0]  rnd;
    int sent;
    int startPop;
    for (int j = 0; j < 4; j++) begin
      rnd = $urandom;
      bpA[j] = rnd[W-1:0];
      rnd = $urandom;
      bpB[j] = rnd[W-1:0];
    end
    outReady = 1'b0;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      if (sent < 4) applyStimulus(1'b1, bpA[sent], bpB[sent], sent[0], sent[1]);
      else          applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      stepCycle();
      if (obsAccept) sent++;
    end
    checkOutput("bpAccepted", sent, S);
    checkOutput("bpInReadyLow", obsInReady, 1'b0);
    outReady = 1'b1;
    startPop = popCount;
    for (int c = 0; c < 4; c++) begin
      if (sent < 4) applyStimulus(1'b1, bpA[sent], bpB[sent], sent[0], sent[1]);
      else          applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      stepCycle();
      if (obsAccept) sent++;
      checkOutput("bpNoGap", obsValid, 1'b1);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("bpAllSent", sent, 4);
    checkOutput("bpDelivered", popCount - startPop, 4);
  endtask

  task automatic midResetTest();
    int staleCount;
    outReady = 1'b0;
    applyStimulus(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 16'h00FF, 16'h0F0F, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("preRstOutValid", outValid, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midRstOutValid", outValid, 1'b0);
    checkOutput("midRstSum", sumOut, 16'h0000);
    checkOutput("midRstCout", coutOut, 1'b0);
    expQ.delete();
    pushCount = popCount;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midRstInReady", inReady, 1'b1);
    outReady = 1'b1;
    staleCount = 0;
    repeat (6) begin
      stepCycle();
      if (obsValid) staleCount++;
    end
    checkOutput("midRstStale", staleCount, 0);
  endtask

  task automatic randomPhase(input int nCycles);
    logic [31:0]  rnd;
    logic [31:0]  val;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    for (int c = 0; c < nCycles; c++) begin
      rnd = $urandom;
      val = $urandom;
      va  = (rnd[3:2] == 2'b00) ? edgeVals[rnd[5:4]] : val[W-1:0];
      vb  = (rnd[13:12] == 2'b00) ? edgeVals[rnd[7:6]] : val[2*W-1:W];
      applyStimulus(rnd[1:0] != 2'b00, va, vb, rnd[8], rnd[9]);
      outReady = (rnd[11:10] != 2'b00);
      stepCycle();
    end
  endtask

  initial begin
    rst      = 1'b1;
    outReady = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    checkOutput("rstOutValid", outValid, 1'b0);
    checkOutput("rstSum", sumOut, 16'h0000);
    checkOutput("rstCout", coutOut, 1'b0);
    checkOutput("rstOvf", ovfOut, 1'b0);
    checkOutput("rstZero", zeroOut, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("inReadyAfterRst", inReady, 1'b1);

    runSingle("wrapZero", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    runSingle("posOvf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    runSingle("subBorrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    runSingle("cinAdd", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

    backpressureTest();
    midResetTest();
    randomPhase(3000);

    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    outReady = 1'b1;
    for (int c = 0; c < 50 && expQ.size() > 0; c++) stepCycle();
    checkOutput("drainCount", popCount, pushCount);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
